// File: rtl/pla_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pla_pkg : shared Q4.12 constants, state type and chirp helper    |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
package pla_pkg;

  localparam int WI      = 4;
  localparam int WF      = 12;
  localparam int W       = WI + WF;
  localparam int COS_LAT = 3;

  localparam logic [W-1:0] TWO_PI_Q412 = 16'd25736;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Step the chirp frequency toward its ceiling; 17-bit sum so the compare cannot overflow.
  function automatic logic [W-1:0] next_fcw(input logic [W-1:0] f,
                                            input logic [W-1:0] step,
                                            input logic [W-1:0] fmax);
    logic [W:0] s;
    s = {1'b0, f} + {1'b0, step};
    if ((step == '0) || (f >= fmax))
      return f;
    else if (s >= {1'b0, fmax})
      return fmax;
    else
      return s[W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_wrap_add.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | phase_wrap_add : 16+16 -> 17-bit add with one modulo-2pi subtract|
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module phase_wrap_add #(
  parameter int          W      = 16,
  parameter logic [W-1:0] TWO_PI = 16'd25736
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  logic [W:0] w_sum;
  logic [W:0] w_red;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_red = (w_sum >= {1'b0, TWO_PI}) ? (w_sum - {1'b0, TWO_PI}) : w_sum;
  // Only reachable for out-of-range operands (e.g. phase_init near full scale).
  assign o_y   = (w_red >= {1'b0, TWO_PI}) ? '0 : w_red[W-1:0];

endmodule
`default_nettype wire

// File: rtl/pla_phase_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pla_phase_gen : Q4.12 phase/chirp generator for the PLA cosine   |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module pla_phase_gen #(
  parameter int                  WI      = pla_pkg::WI,
  parameter int                  WF      = pla_pkg::WF,
  parameter logic [WI+WF-1:0]    TWO_PI  = pla_pkg::TWO_PI_Q412,
  parameter int                  CNT_W   = 16,
  parameter int                  COS_LAT = pla_pkg::COS_LAT
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                stop,
  input  logic [WI+WF-1:0]    phase_init,
  input  logic [WI+WF-1:0]    fcw,
  input  logic [WI+WF-1:0]    fcw_step,
  input  logic [WI+WF-1:0]    fcw_max,
  input  logic [CNT_W-1:0]    n_samples,
  output logic [WI+WF-1:0]    x_out,
  output logic                x_valid,
  output logic                y_valid,
  output logic                busy,
  output logic                done
);

  import pla_pkg::*;

  localparam int                 c_w      = WI + WF;
  localparam logic [c_w-1:0]     c_max    = TWO_PI - 1'b1;
  localparam logic [COS_LAT-1:0] c_last_y = COS_LAT'(1) << (COS_LAT - 1);

  state_t               r_state, w_state_nxt;
  logic [c_w-1:0]       r_x_out, w_x_out;
  logic [c_w-1:0]       r_phase, w_phase;
  logic [c_w-1:0]       r_fcw_cur, w_fcw;
  logic [CNT_W-1:0]     r_count, w_count;
  logic                 r_x_valid, w_x_valid;
  logic                 r_done, w_done;
  logic                 r_busy;
  logic [COS_LAT-1:0]   r_dly;

  logic [c_w-1:0]       w_fcw_c, w_max_c, w_init_red;
  logic [c_w-1:0]       w_add_a, w_add_b, w_phase_sum;

  assign w_fcw_c = (fcw     >= TWO_PI) ? c_max : fcw;
  assign w_max_c = (fcw_max >= TWO_PI) ? c_max : fcw_max;

  phase_wrap_add #(.W(c_w), .TWO_PI(TWO_PI)) u_init_red (
    .i_a (phase_init),
    .i_b ('0),
    .o_y (w_init_red)
  );

  // One adder serves both the first sample (from the load path) and every RUN sample.
  assign w_add_a = (r_state == IDLE) ? w_init_red : r_phase;
  assign w_add_b = (r_state == IDLE) ? w_fcw_c    : r_fcw_cur;

  phase_wrap_add #(.W(c_w), .TWO_PI(TWO_PI)) u_phase_add (
    .i_a (w_add_a),
    .i_b (w_add_b),
    .o_y (w_phase_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_x_out     = r_x_out;
    w_x_valid   = 1'b0;
    w_phase     = r_phase;
    w_fcw       = r_fcw_cur;
    w_count     = r_count;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_x_out     = w_init_red;
          w_x_valid   = 1'b1;
          w_phase     = w_phase_sum;
          w_fcw       = next_fcw(w_fcw_c, fcw_step, w_max_c);
          w_count     = CNT_W'(1);
          w_state_nxt = (n_samples == CNT_W'(1)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = DRAIN;
        end else begin
          w_x_out   = r_phase;
          w_x_valid = 1'b1;
          w_phase   = w_phase_sum;
          w_fcw     = next_fcw(r_fcw_cur, fcw_step, w_max_c);
          w_count   = (r_count == '1) ? r_count : r_count + CNT_W'(1);
          if ((n_samples != '0) && (r_count == n_samples - CNT_W'(1)))
            w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Fire when the final y_valid is on the delay-line output with nothing behind it.
        if (r_done)
          w_state_nxt = IDLE;
        else if (!r_x_valid && (r_dly == c_last_y))
          w_done = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_phase   <= '0;
      r_fcw_cur <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x_out   <= w_x_out;
      r_x_valid <= w_x_valid;
      r_phase   <= w_phase;
      r_fcw_cur <= w_fcw;
      r_count   <= w_count;
      r_done    <= w_done;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  generate
    if (COS_LAT == 1) begin : g_dly_single
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_dly <= '0;
        else        r_dly <= r_x_valid;
      end
    end else begin : g_dly_shift
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_dly <= '0;
        else        r_dly <= {r_dly[COS_LAT-2:0], r_x_valid};
      end
    end
  endgenerate

  assign x_out   = r_x_out;
  assign x_valid = r_x_valid;
  assign y_valid = r_dly[COS_LAT-1];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pla_phase_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_pla_phase_gen : directed bench for pla_phase_gen              |
// | Revision: 1.0                                                    |
// +-----------------------------------------------------------------+
module tb_pla_phase_gen;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        stop;
  logic [15:0] phase_init;
  logic [15:0] fcw;
  logic [15:0] fcw_step;
  logic [15:0] fcw_max;
  logic [15:0] n_samples;
  logic [15:0] x_out;
  logic        x_valid;
  logic        y_valid;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] burst_x [4] = '{16'd0, 16'd1024, 16'd2048, 16'd3072};
  logic [15:0] wrap_x  [3] = '{16'd25000, 16'd264, 16'd1264};
  logic [15:0] chirp_x [5] = '{16'd0, 16'd100, 16'd250, 16'd450, 16'd650};

  pla_phase_gen dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .stop       (stop),
    .phase_init (phase_init),
    .fcw        (fcw),
    .fcw_step   (fcw_step),
    .fcw_max    (fcw_max),
    .n_samples  (n_samples),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .y_valid    (y_valid),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_run(input logic [15:0] pi, input logic [15:0] f,
                         input logic [15:0] st, input logic [15:0] mx,
                         input logic [15:0] n);
    phase_init = pi;
    fcw        = f;
    fcw_step   = st;
    fcw_max    = mx;
    n_samples  = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else               tick();
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; start = 1'b0; stop = 1'b0;
    phase_init = '0; fcw = '0; fcw_step = '0; fcw_max = '0; n_samples = '0;
    repeat (2) @(negedge CLK);
    chk("rst_x_out",   32'(x_out),   32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    RST_N = 1'b1;
    tick();

    // Basic burst: x valid cycles 1..4, y valid 4..7, done 8, idle 9
    set_run(16'd0, 16'd1024, 16'd0, 16'd0, 16'd4);
    for (int k = 1; k <= 9; k++) begin
      chk("burst_xv",   32'(x_valid), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) chk("burst_x", 32'(x_out), 32'(burst_x[k-1]));
      chk("burst_yv",   32'(y_valid), (k >= 4 && k <= 7) ? 32'd1 : 32'd0);
      chk("burst_done", 32'(done),    (k == 8) ? 32'd1 : 32'd0);
      chk("burst_busy", 32'(busy),    (k <= 8) ? 32'd1 : 32'd0);
      tick();
    end

    // Wrap-around
    set_run(16'd25000, 16'd1000, 16'd0, 16'd0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_xv", 32'(x_valid), 32'd1);
      chk("wrap_x",  32'(x_out),   32'(wrap_x[i]));
      tick();
    end
    chk("wrap_xv_end", 32'(x_valid), 32'd0);
    wait_done("wrap");

    // Linear chirp with ceiling
    set_run(16'd0, 16'd100, 16'd50, 16'd200, 16'd5);
    for (int i = 0; i < 5; i++) begin
      chk("chirp_xv", 32'(x_valid), 32'd1);
      chk("chirp_x",  32'(x_out),   32'(chirp_x[i]));
      tick();
    end
    chk("chirp_xv_end", 32'(x_valid), 32'd0);
    wait_done("chirp");

    // Stop in continuous mode: two samples, y at cycles 4..5, done at 6
    set_run(16'd0, 16'd512, 16'd0, 16'd0, 16'd0);
    chk("stop_x0", 32'(x_out), 32'd0);
    tick();
    chk("stop_x1", 32'(x_out), 32'd512);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_xv",    32'(x_valid), 32'd0);
    chk("stop_busy",  32'(busy),    32'd1);
    tick();
    chk("stop_yv4",   32'(y_valid), 32'd1);
    tick();
    chk("stop_yv5",   32'(y_valid), 32'd1);
    chk("stop_done5", 32'(done),    32'd0);
    tick();
    chk("stop_done6", 32'(done),    32'd1);
    chk("stop_yv6",   32'(y_valid), 32'd0);
    tick();
    chk("stop_idle",  32'(busy),    32'd0);
    chk("stop_done7", 32'(done),    32'd0);

    start = 1'b1; stop = 1'b1;
    tick();
    chk("both_xv",   32'(x_valid), 32'd0);
    chk("both_busy", 32'(busy),    32'd0);
    start = 1'b0; stop = 1'b0;
    tick();
    chk("both_busy2", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN
    set_run(16'd0, 16'd1024, 16'd0, 16'd0, 16'd0);
    tick();
    chk("prerst_x", 32'(x_out), 32'd1024);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_x_out",   32'(x_out),   32'd0);
    chk("arst_x_valid", 32'(x_valid), 32'd0);
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_y_valid", 32'(y_valid), 32'd0);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);
    tick();
    chk("arst_done2", 32'(done),    32'd0);
    chk("arst_yv2",   32'(y_valid), 32'd0);

    // Single-sample burst: x at 1, y at 4, done at 5
    set_run(16'd0, 16'd1024, 16'd0, 16'd0, 16'd1);
    chk("one_xv", 32'(x_valid), 32'd1);
    chk("one_x",  32'(x_out),   32'd0);
    tick();
    chk("one_xv2",   32'(x_valid), 32'd0);
    chk("one_busy2", 32'(busy),    32'd1);
    tick();
    tick();
    chk("one_yv4",   32'(y_valid), 32'd1);
    chk("one_done4", 32'(done),    32'd0);
    tick();
    chk("one_done5", 32'(done),    32'd1);
    tick();
    chk("one_idle",  32'(busy),    32'd0);

    // Clamping of fcw and phase_init
    set_run(16'd30000, 16'd30000, 16'd0, 16'd0, 16'd2);
    chk("clamp_x0", 32'(x_out), 32'd4264);
    tick();
    chk("clamp_x1", 32'(x_out), 32'd4263);
    tick();
    chk("clamp_xv_end", 32'(x_valid), 32'd0);
    wait_done("clamp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
